// File: rtl/tug_if.sv
// Press inputs and display/score outputs shared between the input conditioners,
// the tug-of-war referee and the display drivers.
interface tug_if #(
  parameter int N_LIGHTS = 9,
  parameter int SCORE_W  = 3
);
  logic                L;
  logic                R;
  logic [N_LIGHTS-1:0] lights;
  logic [1:0]          winner;
  logic [SCORE_W-1:0]  leftScore;
  logic [SCORE_W-1:0]  rightScore;
  logic                gameOver;

  modport master (
    output L, R,
    input  lights, winner, leftScore, rightScore, gameOver
  );

  modport slave (
    input  L, R,
    output lights, winner, leftScore, rightScore, gameOver
  );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war referee: arbitrates press pulses, moves the playfield light,
// scores rounds and sequences PLAY -> HOLD -> PLAY, or into DONE at the final score.
module tug_referee #(
  parameter int N_LIGHTS    = 9,
  parameter int HOLD_CYCLES = 4,
  parameter int SCORE_W     = 3
) (
  input logic  Clock,
  input logic  Reset,
  tug_if.slave bus
);

  localparam int PW = $clog2(N_LIGHTS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [PW-1:0]      POS_CENTER = PW'((N_LIGHTS - 1) / 2);
  localparam logic [PW-1:0]      POS_LEFT   = PW'(N_LIGHTS - 1);
  localparam logic [PW-1:0]      POS_RIGHT  = '0;
  localparam logic [HW-1:0]      HOLD_END   = HW'(HOLD_CYCLES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [SCORE_W-1:0]  left_q, left_d;
  logic [SCORE_W-1:0]  right_q, right_d;
  logic [1:0]          winner_q, winner_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic                over_q, over_d;

  // Saturating increment; DONE is entered at SCORE_MAX so the clamp is a safety net.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

  function automatic logic [N_LIGHTS-1:0] one_hot(input logic [PW-1:0] p);
    logic [N_LIGHTS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hold_d   = hold_q;
    left_d   = left_q;
    right_d  = right_q;
    winner_d = winner_q;

    unique case (state_q)
      PLAY: begin
        // Simultaneous presses cancel, so only a lone press is acted on.
        if (bus.L && !bus.R) begin
          if (pos_q == POS_LEFT) begin
            left_d   = score_inc(left_q);
            winner_d = 2'b01;
            hold_d   = '0;
            state_d  = (score_inc(left_q) == SCORE_MAX) ? DONE : HOLD;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (bus.R && !bus.L) begin
          if (pos_q == POS_RIGHT) begin
            right_d  = score_inc(right_q);
            winner_d = 2'b10;
            hold_d   = '0;
            state_d  = (score_inc(right_q) == SCORE_MAX) ? DONE : HOLD;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end

      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_d == HOLD_END) begin
          state_d  = PLAY;
          pos_d    = POS_CENTER;
          winner_d = 2'b00;
        end
      end

      DONE: begin
      end

      default: state_d = PLAY;
    endcase

    lights_d = (state_d == PLAY) ? one_hot(pos_d) : '0;
    over_d   = (state_d == DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= PLAY;
      pos_q    <= POS_CENTER;
      hold_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      winner_q <= 2'b00;
      lights_q <= one_hot(POS_CENTER);
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      hold_q   <= hold_d;
      left_q   <= left_d;
      right_q  <= right_d;
      winner_q <= winner_d;
      lights_q <= lights_d;
      over_q   <= over_d;
    end
  end

  assign bus.lights     = lights_q;
  assign bus.winner     = winner_q;
  assign bus.leftScore  = left_q;
  assign bus.rightScore = right_q;
  assign bus.gameOver   = over_q;

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for tug_referee: two instances (SCORE_W=3 and SCORE_W=2) share stimulus
// and are compared every cycle against a plain-integer game model plus literal expectations.
module tb_tug_referee;

  localparam int N  = 9;
  localparam int HC = 4;
  localparam int C  = (N - 1) / 2;

  logic Clock = 1'b0;
  logic Reset;
  logic L;
  logic R;

  always #5 Clock = ~Clock;

  tug_if #(.N_LIGHTS(N), .SCORE_W(3)) bus3 ();
  tug_if #(.N_LIGHTS(N), .SCORE_W(2)) bus2 ();

  assign bus3.L = L;
  assign bus3.R = R;
  assign bus2.L = L;
  assign bus2.R = R;

  tug_referee #(.N_LIGHTS(N), .HOLD_CYCLES(HC), .SCORE_W(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .bus(bus3)
  );
  tug_referee #(.N_LIGHTS(N), .HOLD_CYCLES(HC), .SCORE_W(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .bus(bus2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Game model: mode 0=playing, 1=showing a round win, 2=game over.
  int m_mode [2];
  int m_pos  [2];
  int m_hold [2];
  int m_win  [2];
  int m_ls   [2];
  int m_rs   [2];
  int m_max  [2] = '{7, 3};
  bit m_valid = 1'b0;

  always @(posedge Clock) begin
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        m_mode[k] = 0; m_pos[k] = C; m_hold[k] = 0;
        m_win[k]  = 0; m_ls[k]  = 0; m_rs[k]   = 0;
      end else if (m_mode[k] == 0) begin
        if (L && !R) begin
          if (m_pos[k] == N - 1) begin
            m_ls[k]   = m_ls[k] + 1;
            m_win[k]  = 1;
            m_hold[k] = 0;
            m_mode[k] = (m_ls[k] == m_max[k]) ? 2 : 1;
          end else m_pos[k] = m_pos[k] + 1;
        end else if (R && !L) begin
          if (m_pos[k] == 0) begin
            m_rs[k]   = m_rs[k] + 1;
            m_win[k]  = 2;
            m_hold[k] = 0;
            m_mode[k] = (m_rs[k] == m_max[k]) ? 2 : 1;
          end else m_pos[k] = m_pos[k] - 1;
        end
      end else if (m_mode[k] == 1) begin
        m_hold[k] = m_hold[k] + 1;
        if (m_hold[k] == HC) begin
          m_mode[k] = 0; m_pos[k] = C; m_win[k] = 0;
        end
      end
    end
    if (Reset) m_valid = 1'b1;
  end

  function automatic int exp_lights(input int k);
    return (m_mode[k] == 0) ? (1 << m_pos[k]) : 0;
  endfunction

  always @(negedge Clock) begin
    if (m_valid) begin
      cmp("m3_lights", int'(bus3.lights),     exp_lights(0));
      cmp("m3_winner", int'(bus3.winner),     m_win[0]);
      cmp("m3_lscore", int'(bus3.leftScore),  m_ls[0]);
      cmp("m3_rscore", int'(bus3.rightScore), m_rs[0]);
      cmp("m3_over",   int'(bus3.gameOver),   (m_mode[0] == 2) ? 1 : 0);
      cmp("m2_lights", int'(bus2.lights),     exp_lights(1));
      cmp("m2_winner", int'(bus2.winner),     m_win[1]);
      cmp("m2_lscore", int'(bus2.leftScore),  m_ls[1]);
      cmp("m2_rscore", int'(bus2.rightScore), m_rs[1]);
      cmp("m2_over",   int'(bus2.gameOver),   (m_mode[1] == 2) ? 1 : 0);
    end
  end

  task automatic pulse(input logic l, input logic r);
    L = l; R = r;
    @(negedge Clock);
    L = 1'b0; R = 1'b0;
    @(negedge Clock);
  endtask

  task automatic left_round();
    repeat (5) pulse(1'b1, 1'b0);
    repeat (3) @(negedge Clock);
  endtask

  task automatic check_reset_state(input string tag);
    cmp({tag, "_lights3"}, int'(bus3.lights),     int'(9'b000010000));
    cmp({tag, "_winner3"}, int'(bus3.winner),     0);
    cmp({tag, "_ls3"},     int'(bus3.leftScore),  0);
    cmp({tag, "_rs3"},     int'(bus3.rightScore), 0);
    cmp({tag, "_over3"},   int'(bus3.gameOver),   0);
    cmp({tag, "_lights2"}, int'(bus2.lights),     int'(9'b000010000));
    cmp({tag, "_winner2"}, int'(bus2.winner),     0);
    cmp({tag, "_ls2"},     int'(bus2.leftScore),  0);
    cmp({tag, "_over2"},   int'(bus2.gameOver),   0);
  endtask

  initial begin
    Reset = 1'b1; L = 1'b0; R = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check_reset_state("rst");

    // Walk left to the edge, then win from the edge.
    repeat (4) pulse(1'b1, 1'b0);
    cmp("left_edge", int'(bus3.lights), int'(9'b100000000));
    pulse(1'b1, 1'b0);
    cmp("lwin_winner", int'(bus3.winner),    1);
    cmp("lwin_score",  int'(bus3.leftScore), 1);
    cmp("lwin_lights", int'(bus3.lights),    0);
    repeat (3) @(negedge Clock);
    cmp("resume_lights", int'(bus3.lights), int'(9'b000010000));
    cmp("resume_winner", int'(bus3.winner), 0);

    pulse(1'b1, 1'b1);
    cmp("both_cancel", int'(bus3.lights), int'(9'b000010000));
    pulse(1'b0, 1'b1);
    cmp("right_step", int'(bus3.lights), int'(9'b000001000));

    // Right win, then presses during HOLD including one on the leaving edge.
    repeat (4) pulse(1'b0, 1'b1);
    cmp("rwin_winner", int'(bus3.winner),     2);
    cmp("rwin_score",  int'(bus3.rightScore), 1);
    pulse(1'b1, 1'b0);
    cmp("hold_ignore_l", int'(bus3.lights), 0);
    pulse(1'b0, 1'b1);
    cmp("hold_resume", int'(bus3.lights), int'(9'b000010000));

    // SCORE_W=2 instance saturates at 3; SCORE_W=3 instance keeps going to 7.
    left_round();
    left_round();
    cmp("sat2_over",   int'(bus2.gameOver),  1);
    cmp("sat2_score",  int'(bus2.leftScore), 3);
    cmp("sat2_winner", int'(bus2.winner),    1);
    cmp("sat2_lights", int'(bus2.lights),    0);
    cmp("sat3_play",   int'(bus3.gameOver),  0);
    repeat (4) left_round();
    cmp("sat3_over",  int'(bus3.gameOver),   1);
    cmp("sat3_score", int'(bus3.leftScore),  7);
    cmp("done2_ls",   int'(bus2.leftScore),  3);
    cmp("done2_rs",   int'(bus2.rightScore), 1);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    cmp("done3_hold", int'(bus3.leftScore), 7);

    // Reset takes priority over a simultaneous press.
    Reset = 1'b1; L = 1'b1;
    @(negedge Clock);
    Reset = 1'b0; L = 1'b0;
    check_reset_state("rst_done");

    // Reset two cycles into HOLD.
    repeat (5) pulse(1'b0, 1'b1);
    cmp("mid_rs",     int'(bus3.rightScore), 1);
    cmp("mid_winner", int'(bus3.winner),     2);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check_reset_state("rst_hold");

    pulse(1'b1, 1'b0);
    cmp("post_rst_move", int'(bus3.lights), int'(9'b000100000));
    repeat (2) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
